// File: rtl/button_events_pkg.sv
// Shared types and tick conversion for the button front end.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, SHORT, LONG} btn_state_t;

    function automatic int ms_to_ticks(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_events_if.sv
// Raw levels in, debounced level and event pulses out, one bit per channel.
interface button_events_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] raw_pressed;
    logic [N_BTN-1:0] held;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] click;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] repeat_evt;
    logic             any_event;

    modport master (output raw_pressed,
                    input  held, press, click, long_press, repeat_evt, any_event);
    modport slave  (input  raw_pressed,
                    output held, press, click, long_press, repeat_evt, any_event);
endinterface

// File: rtl/button_events_channel.sv
// One button: 2-flop synchroniser, symmetric debouncer and press classifier.
module button_channel
    import btn_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_pressed,
    output logic held,
    output logic press,
    output logic click,
    output logic long_press,
    output logic repeat_evt,
    output logic event_next
);
    localparam int DB_TICKS     = ms_to_ticks(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_TICKS   = ms_to_ticks(CLK_HZ, LONG_MS);
    localparam int REPEAT_TICKS = ms_to_ticks(CLK_HZ, REPEAT_MS);
    localparam int MAX_A        = (DB_TICKS > LONG_TICKS) ? DB_TICKS : LONG_TICKS;
    localparam int MAX_T        = (MAX_A > REPEAT_TICKS) ? MAX_A : REPEAT_TICKS;
    localparam int CNT_W        = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    if (DB_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
        $error("button_channel: every tick constant must be >= 1");
    end

    logic             s1, s;
    logic [CNT_W-1:0] dcnt, hcnt;
    btn_state_t       state;

    logic toggle, rise, fall;
    logic press_d, click_d, long_d, rep_d;

    // Pulses are decided from the edge that updates held so they line up with it.
    always_comb begin
        toggle     = (s != held) && (dcnt == DB_LAST);
        rise       = toggle && !held;
        fall       = toggle && held;
        press_d    = rise && (state == IDLE);
        click_d    = fall && (state == SHORT);
        long_d     = !fall && (state == SHORT) && (hcnt == LONG_LAST);
        rep_d      = !fall && (state == LONG)  && (hcnt == REP_LAST);
        event_next = press_d | click_d | long_d | rep_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b0;
            s          <= 1'b0;
            held       <= 1'b0;
            dcnt       <= '0;
            hcnt       <= '0;
            state      <= IDLE;
            press      <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
            repeat_evt <= 1'b0;
        end else begin
            s1 <= raw_pressed;
            s  <= s1;

            if (s == held) begin
                dcnt <= '0;
            end else if (toggle) begin
                held <= ~held;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end

            press      <= press_d;
            click      <= click_d;
            long_press <= long_d;
            repeat_evt <= rep_d;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= SHORT;
                        hcnt  <= '0;
                    end
                end
                SHORT: begin
                    if (fall) begin
                        state <= IDLE;
                    end else if (long_d) begin
                        state <= LONG;
                        hcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall)       state <= IDLE;
                    else if (rep_d) hcnt  <= '0;
                    else            hcnt  <= hcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/button_events.sv
// N independent button channels plus a registered any_event summary.
module button_events
    import btn_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int REPEAT_MS   = 200
) (
    input logic            clk,
    input logic            reset,
    button_events_if.slave bus
);
    logic [N_BTN-1:0] held, press, click, long_press, repeat_evt, ev_next;
    logic             any_event;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .CLK_HZ      (CLK_HZ),
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .raw_pressed (bus.raw_pressed[i]),
            .held        (held[i]),
            .press       (press[i]),
            .click       (click[i]),
            .long_press  (long_press[i]),
            .repeat_evt  (repeat_evt[i]),
            .event_next  (ev_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) any_event <= 1'b0;
        else       any_event <= |ev_next;
    end

    assign bus.held       = held;
    assign bus.press      = press;
    assign bus.click      = click;
    assign bus.long_press = long_press;
    assign bus.repeat_evt = repeat_evt;
    assign bus.any_event  = any_event;
endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench: a timing-rule model predicts every output cycle, a monitor compares.
module tb_button_events;
    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    typedef struct packed {
        logic [N-1:0] held;
        logic [N-1:0] press;
        logic [N-1:0] click;
        logic [N-1:0] lng;
        logic [N-1:0] rep;
        logic         any;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    button_events_if #(.N_BTN(N)) bus ();

    button_events #(
        .N_BTN(N), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 0;

    // Reference model: held flips once the synchronised level has disagreed with it
    // for DB consecutive cycles; events follow from time elapsed since the press.
    bit m_s1[N], m_s[N], m_held[N];
    bit hist[N][$];
    int t_press[N];
    int cyc = 0;

    initial forever begin
        obs_t e;
        bit   tog;
        int   d;
        @(posedge clk);
        e = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (reset) begin
                m_s1[ch] = 0; m_s[ch] = 0; m_held[ch] = 0;
                hist[ch].delete();
            end else begin
                hist[ch].push_back(m_s[ch]);
                if (hist[ch].size() > DB) void'(hist[ch].pop_front());
                tog = (hist[ch].size() == DB);
                foreach (hist[ch][k]) if (hist[ch][k] == m_held[ch]) tog = 0;
                m_s[ch]  = m_s1[ch];
                m_s1[ch] = bus.raw_pressed[ch];
                d = cyc - t_press[ch];
                if (tog && !m_held[ch]) begin
                    e.press[ch] = 1;
                    t_press[ch] = cyc;
                end else if (tog && m_held[ch]) begin
                    if (d <= LONG) e.click[ch] = 1;
                end else if (m_held[ch]) begin
                    if (d == LONG) e.lng[ch] = 1;
                    if (d > LONG && ((d - LONG) % REP) == 0) e.rep[ch] = 1;
                end
                m_held[ch] = m_held[ch] ^ tog;
                e.held[ch] = m_held[ch];
            end
        end
        e.any = |{e.press, e.click, e.lng, e.rep};
        exp_q.push_back(e);
        cyc++;
    end

    initial forever begin
        obs_t got, want;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{bus.held, bus.press, bus.click, bus.long_press, bus.repeat_evt, bus.any_event};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got held=%b press=%b click=%b long=%b rep=%b any=%b, want held=%b press=%b click=%b long=%b rep=%b any=%b",
                         cyc - 1, got.held, got.press, got.click, got.lng, got.rep, got.any,
                         want.held, want.press, want.click, want.lng, want.rep, want.any);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: stimulus did not complete, %0d vectors applied", vectors);
            $finish;
        end
    end

    task automatic hold(input logic [N-1:0] r, input logic rs, input int n);
        bus.raw_pressed = r;
        reset = rs;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        int run_left[N];
        hold('0, 1'b1, 3);
        if ({bus.held, bus.press, bus.click, bus.long_press, bus.repeat_evt, bus.any_event} !== '0) begin
            miscompares++;
            $display("FAIL reset state: held=%b press=%b click=%b long=%b rep=%b any=%b",
                     bus.held, bus.press, bus.click, bus.long_press, bus.repeat_evt, bus.any_event);
        end
        hold('0, 1'b0, 5);
        // glitch shorter than debounce
        hold(4'b0001, 1'b0, 3);
        hold('0, 1'b0, 20);
        // short press -> click
        hold(4'b0010, 1'b0, 12);
        hold('0, 1'b0, 30);
        // long press with repeats, release suppresses repeat
        hold(4'b0100, 1'b0, 40);
        hold('0, 1'b0, 30);
        // simultaneous channels
        hold(4'b1001, 1'b0, 10);
        hold('0, 1'b0, 30);
        // reset in the middle of a held press
        hold(4'b0010, 1'b0, 10);
        hold(4'b0010, 1'b1, 1);
        hold(4'b0010, 1'b0, 20);
        hold('0, 1'b0, 30);
        // release bounce
        hold(4'b0100, 1'b0, 15);
        hold('0, 1'b0, 2);
        hold(4'b0100, 1'b0, 2);
        hold('0, 1'b0, 30);
        // random, including glitches, long holds and occasional resets
        r = '0;
        foreach (run_left[i]) run_left[i] = $urandom_range(1, 45);
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                run_left[ch]--;
                if (run_left[ch] <= 0) begin
                    r[ch] = ~r[ch];
                    run_left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                               : $urandom_range(6, 60);
                end
            end
            hold(r, ($urandom_range(0, 499) == 0), 1);
        end
        hold('0, 1'b0, 80);
        @(negedge clk);
        @(negedge clk);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares == %s", vectors, miscompares,
                 (miscompares == 0) ? "PASS" : "FAIL");
        $finish;
    end
endmodule
